elevator_ctrl_n: RTL and testbench

Parametrised N-floor elevator controller. Latches interior and exterior call buttons, serves requests with a directional (SCAN) policy, and times door dwell and inter-floor travel from a slow timebase enable. Sits between the button-panel debouncers and the engine/door drivers. Replaces the fixed 3-floor controller.

---
 rtl/elev_pkg.sv | 28 ++
 rtl/elevator_ctrl_n_if.sv | 53 +++++
 rtl/elev_request_reg.sv | 50 +++++
 rtl/elevator_ctrl_n.sv | 184 ++++++++++++++++++
 tb/tb_elevator_ctrl_n.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/elev_pkg.sv
`default_nettype none
// ============================================================================
// Module   : elev_pkg
// Purpose  : Shared state encoding and engine/direction codes for the
//            N-floor elevator controller.
// Revision : 1.0 - initial release
// ============================================================================
package elev_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DOOR_OPEN = 2'd1,
        MOVING    = 2'd2
    } elev_state_e;

    localparam logic [1:0] ENGINE_OFF  = 2'b00;
    localparam logic [1:0] ENGINE_UP   = 2'b10;
    localparam logic [1:0] ENGINE_DOWN = 2'b11;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic logic [1:0] engine_for(input logic dir);
        return (dir == DIR_UP) ? ENGINE_UP : ENGINE_DOWN;
    endfunction

endpackage
`default_nettype wire

// File: rtl/elevator_ctrl_n_if.sv
`default_nettype none
// ============================================================================
// Module   : elevator_ctrl_n_if
// Purpose  : Button-panel / engine / door bundle of the elevator controller.
//            fire_recall exists only when ELEV_FIRE_RECALL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface elevator_ctrl_n_if #(
    parameter int FLOORS  = 3,
    parameter int FLOOR_W = $clog2(FLOORS)
);
    logic               tick;
    logic [FLOORS-1:0]  interior_panel;
    logic [FLOORS-1:0]  exterior_panel;
    logic [1:0]         engine;
    logic [FLOORS-1:0]  doors;
    logic [FLOOR_W-1:0] cur_floor;
    logic               direction;
    logic [FLOORS-1:0]  requests;
`ifdef ELEV_FIRE_RECALL_EN
    logic               fire_recall;
`endif

    modport master (
`ifdef ELEV_FIRE_RECALL_EN
        output fire_recall,
`endif
        output tick,
        output interior_panel,
        output exterior_panel,
        input  engine,
        input  doors,
        input  cur_floor,
        input  direction,
        input  requests
    );

    modport slave (
`ifdef ELEV_FIRE_RECALL_EN
        input  fire_recall,
`endif
        input  tick,
        input  interior_panel,
        input  exterior_panel,
        output engine,
        output doors,
        output cur_floor,
        output direction,
        output requests
    );

endinterface
`default_nettype wire

// File: rtl/elev_request_reg.sv
`default_nettype none
// ============================================================================
// Module   : elev_request_reg
// Purpose  : Latched floor requests with single-floor clear, plus masks of
//            requests above and below the current floor.
// Revision : 1.0 - initial release
// ============================================================================
module elev_request_reg #(
    parameter int FLOORS  = 3,
    parameter int FLOOR_W = $clog2(FLOORS)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [FLOORS-1:0]  set_mask,
    input  logic               clr_en,
    input  logic [FLOOR_W-1:0] clr_idx,
    input  logic               inhibit,
    input  logic [FLOOR_W-1:0] cur_floor,
    output logic [FLOORS-1:0]  requests,
    output logic [FLOORS-1:0]  above,
    output logic [FLOORS-1:0]  below
);

    logic [FLOORS-1:0] r_req;
    logic [FLOORS-1:0] w_clr_oh;

    assign w_clr_oh = clr_en ? (FLOORS'(1) << clr_idx) : '0;

    // Clear beats a simultaneous press only on the floor being cleared.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_req <= '0;
        end else if (inhibit) begin
            r_req <= '0;
        end else begin
            r_req <= (r_req | set_mask) & ~w_clr_oh;
        end
    end

    assign requests = inhibit ? '0 : r_req;

    generate
        for (genvar i = 0; i < FLOORS; i++) begin : g_bit
            assign above[i] = requests[i] & (FLOOR_W'(i) > cur_floor);
            assign below[i] = requests[i] & (FLOOR_W'(i) < cur_floor);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/elevator_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module   : elevator_ctrl_n
// Purpose  : N-floor SCAN elevator controller with tick-timed door dwell and
//            travel. Optional fire recall under ELEV_FIRE_RECALL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module elevator_ctrl_n #(
    parameter int FLOORS       = 3,
    parameter int FLOOR_W      = $clog2(FLOORS),
    parameter int DOOR_TICKS   = 4,
    parameter int TRAVEL_TICKS = 3,
    parameter int CNT_W        = 4
) (
    input  logic             CLK,
    input  logic             RST,
    elevator_ctrl_n_if.slave bus
);
    import elev_pkg::*;

    localparam logic [CNT_W-1:0]   c_door_last   = CNT_W'(DOOR_TICKS - 1);
    localparam logic [CNT_W-1:0]   c_travel_last = CNT_W'(TRAVEL_TICKS - 1);
    localparam logic [FLOOR_W-1:0] c_top_floor   = FLOOR_W'(FLOORS - 1);
    localparam logic [FLOORS-1:0]  c_one         = FLOORS'(1);

    elev_state_e        r_state, w_state_nx;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nx, w_cnt_inc;
    logic [FLOOR_W-1:0] r_floor, w_floor_nx, w_arrive_floor, w_clr_idx;
    logic               r_dir, w_dir_nx, w_dir_eff, w_clr_en;
    logic [FLOORS-1:0]  w_press, w_cur_oh, w_set, w_req, w_above, w_below;
    logic               w_fire, w_fire_rel, w_arrive_hit, w_at_ground;
    logic               w_ahead, w_behind;

`ifdef ELEV_FIRE_RECALL_EN
    logic r_fire_d;

    assign w_fire = bus.fire_recall;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_fire_d <= 1'b0;
        end else begin
            r_fire_d <= w_fire;
        end
    end

    assign w_fire_rel = r_fire_d & ~w_fire;
`else
    assign w_fire     = 1'b0;
    assign w_fire_rel = 1'b0;
`endif

    assign w_press     = bus.interior_panel | bus.exterior_panel;
    assign w_cur_oh    = c_one << r_floor;
    assign w_dir_eff   = w_fire ? DIR_DOWN : r_dir;
    assign w_at_ground = (r_floor == '0);
    assign w_cnt_inc   = r_cnt + CNT_W'(1);

    // A press for the floor whose door is open re-arms the dwell instead.
    assign w_set = w_fire ? '0
                 : (w_press & ~((r_state == DOOR_OPEN) ? w_cur_oh : '0));

    elev_request_reg #(
        .FLOORS  (FLOORS),
        .FLOOR_W (FLOOR_W)
    ) u_req (
        .CLK       (CLK),
        .RST       (RST),
        .set_mask  (w_set),
        .clr_en    (w_clr_en),
        .clr_idx   (w_clr_idx),
        .inhibit   (w_fire),
        .cur_floor (r_floor),
        .requests  (w_req),
        .above     (w_above),
        .below     (w_below)
    );

    assign w_ahead  = (r_dir == DIR_UP) ? (|w_above) : (|w_below);
    assign w_behind = (r_dir == DIR_UP) ? (|w_below) : (|w_above);

    always_comb begin
        w_arrive_floor = r_floor;
        if (w_dir_eff == DIR_UP) begin
            if (r_floor != c_top_floor) begin
                w_arrive_floor = r_floor + FLOOR_W'(1);
            end
        end else if (!w_at_ground) begin
            w_arrive_floor = r_floor - FLOOR_W'(1);
        end
    end

    // Including the live press lets an arrival-cycle call share this stop.
    assign w_arrive_hit = w_fire ? (w_arrive_floor == '0)
                        : (w_req[w_arrive_floor] | w_press[w_arrive_floor]);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= DOOR_OPEN;
            r_cnt   <= '0;
            r_floor <= '0;
            r_dir   <= DIR_UP;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_floor <= w_floor_nx;
            r_dir   <= w_dir_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_floor_nx = r_floor;
        w_dir_nx   = w_dir_eff;
        w_clr_en   = 1'b0;
        w_clr_idx  = r_floor;
        case (r_state)
            DOOR_OPEN: begin
                if (w_fire && w_at_ground) begin
                    w_cnt_nx = r_cnt;
                end else if (w_fire_rel || (!w_fire && w_press[r_floor])) begin
                    w_cnt_nx = '0;
                end else if (bus.tick) begin
                    if (r_cnt == c_door_last) begin
                        w_cnt_nx   = '0;
                        w_state_nx = w_fire ? MOVING : IDLE;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
            end
            IDLE: begin
                w_cnt_nx = '0;
                if (w_fire) begin
                    w_state_nx = w_at_ground ? DOOR_OPEN : MOVING;
                end else if (w_req[r_floor]) begin
                    w_clr_en   = 1'b1;
                    w_state_nx = DOOR_OPEN;
                end else if (w_ahead) begin
                    w_state_nx = MOVING;
                end else if (w_behind) begin
                    w_dir_nx   = ~r_dir;
                    w_state_nx = MOVING;
                end
            end
            MOVING: begin
                if (bus.tick) begin
                    if (r_cnt == c_travel_last) begin
                        w_cnt_nx   = '0;
                        w_floor_nx = w_arrive_floor;
                        if (w_arrive_hit) begin
                            w_clr_en   = 1'b1;
                            w_clr_idx  = w_arrive_floor;
                            w_state_nx = DOOR_OPEN;
                        end
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    always_comb begin
        bus.engine = ENGINE_OFF;
        bus.doors  = '0;
        case (r_state)
            DOOR_OPEN: bus.doors  = w_cur_oh;
            MOVING:    bus.engine = engine_for(w_dir_eff);
            default:   ;
        endcase
    end

    assign bus.cur_floor = r_floor;
    assign bus.direction = w_dir_eff;
    assign bus.requests  = w_req;

endmodule
`default_nettype wire

// File: tb/tb_elevator_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_elevator_ctrl_n
// Purpose  : Self-checking bench: 3-floor vector table plus 8-floor SCAN and
//            reset-while-moving sequences. Ties fire_recall low under
//            ELEV_FIRE_RECALL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_elevator_ctrl_n;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    always #5 CLK = ~CLK;

    elevator_ctrl_n_if #(.FLOORS(3)) if3 ();
    elevator_ctrl_n_if #(.FLOORS(8)) if8 ();

    elevator_ctrl_n #(.FLOORS(3)) u_dut3 (.CLK(CLK), .RST(RST), .bus(if3));
    elevator_ctrl_n #(.FLOORS(8)) u_dut8 (.CLK(CLK), .RST(RST), .bus(if8));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0] ip;
        logic [2:0] ep;
        logic       tk;
        int         rep;
        logic [1:0] eng;
        logic [2:0] drs;
        logic [1:0] cur;
        logic       dir;
        logic [2:0] req;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [2:0] ip, input logic [2:0] ep,
                                input logic tk, input int rep,
                                input logic [1:0] eng, input logic [2:0] drs,
                                input logic [1:0] cur, input logic dir,
                                input logic [2:0] req);
        vec_t v;
        v.ip = ip; v.ep = ep; v.tk = tk; v.rep = rep;
        v.eng = eng; v.drs = drs; v.cur = cur; v.dir = dir; v.req = req;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] snap3();
        return 32'({if3.engine, if3.doors, if3.cur_floor, if3.direction, if3.requests});
    endfunction

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    // Runs ticks until the open door closes and the next one opens.
    task automatic wait_door8(input string name, input int exp_cyc,
                              input logic [2:0] exp_floor, input logic [7:0] exp_doors,
                              input logic exp_dir);
        int cyc = 0;
        if8.tick = 1'b1;
        do begin
            cycle();
            cyc++;
        end while (if8.doors != 8'h00 && cyc < 100);
        while (if8.doors == 8'h00 && cyc < 100) begin
            cycle();
            cyc++;
        end
        if8.tick = 1'b0;
        check({name, " cycles"}, 32'(cyc), 32'(exp_cyc));
        check({name, " floor"}, 32'(if8.cur_floor), 32'(exp_floor));
        check({name, " doors"}, 32'(if8.doors), 32'(exp_doors));
        check({name, " dir"}, 32'(if8.direction), 32'(exp_dir));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef ELEV_FIRE_RECALL_EN
        if3.fire_recall = 1'b0;
        if8.fire_recall = 1'b0;
`endif
        if3.tick = 1'b0; if3.interior_panel = '0; if3.exterior_panel = '0;
        if8.tick = 1'b0; if8.interior_panel = '0; if8.exterior_panel = '0;

        //  ip      ep      tk rep eng    doors   cur   dir   req
        // go from floor 0 to floor 2
        add(3'b100, 3'b000, 1'b0, 1, 2'b00, 3'b001, 2'd0, 1'b1, 3'b100);
        add(3'b000, 3'b000, 1'b1, 3, 2'b00, 3'b001, 2'd0, 1'b1, 3'b100);
        add(3'b000, 3'b000, 1'b1, 1, 2'b00, 3'b000, 2'd0, 1'b1, 3'b100);
        add(3'b000, 3'b000, 1'b0, 1, 2'b10, 3'b000, 2'd0, 1'b1, 3'b100);
        add(3'b000, 3'b000, 1'b1, 2, 2'b10, 3'b000, 2'd0, 1'b1, 3'b100);
        add(3'b000, 3'b000, 1'b1, 1, 2'b10, 3'b000, 2'd1, 1'b1, 3'b100);
        add(3'b000, 3'b000, 1'b1, 2, 2'b10, 3'b000, 2'd1, 1'b1, 3'b100);
        add(3'b000, 3'b000, 1'b1, 1, 2'b00, 3'b100, 2'd2, 1'b1, 3'b000);
        // at floor 2, calls for 0 and 1: reverse, stop at 1
        add(3'b000, 3'b011, 1'b0, 1, 2'b00, 3'b100, 2'd2, 1'b1, 3'b011);
        add(3'b000, 3'b000, 1'b1, 3, 2'b00, 3'b100, 2'd2, 1'b1, 3'b011);
        add(3'b000, 3'b000, 1'b1, 1, 2'b00, 3'b000, 2'd2, 1'b1, 3'b011);
        add(3'b000, 3'b000, 1'b0, 1, 2'b11, 3'b000, 2'd2, 1'b0, 3'b011);
        add(3'b000, 3'b000, 1'b1, 2, 2'b11, 3'b000, 2'd2, 1'b0, 3'b011);
        add(3'b000, 3'b000, 1'b1, 1, 2'b00, 3'b010, 2'd1, 1'b0, 3'b001);
        // dwell at floor 1 extended by its own button
        add(3'b000, 3'b000, 1'b1, 2, 2'b00, 3'b010, 2'd1, 1'b0, 3'b001);
        add(3'b010, 3'b000, 1'b1, 2, 2'b00, 3'b010, 2'd1, 1'b0, 3'b001);
        add(3'b000, 3'b000, 1'b1, 3, 2'b00, 3'b010, 2'd1, 1'b0, 3'b001);
        add(3'b000, 3'b000, 1'b1, 1, 2'b00, 3'b000, 2'd1, 1'b0, 3'b001);
        add(3'b000, 3'b000, 1'b0, 1, 2'b11, 3'b000, 2'd1, 1'b0, 3'b001);
        add(3'b000, 3'b000, 1'b1, 2, 2'b11, 3'b000, 2'd1, 1'b0, 3'b001);
        add(3'b000, 3'b000, 1'b1, 1, 2'b00, 3'b001, 2'd0, 1'b0, 3'b000);
        // heading for 2, floor 1 pressed mid-travel: stop at 1 first
        add(3'b100, 3'b000, 1'b1, 1, 2'b00, 3'b001, 2'd0, 1'b0, 3'b100);
        add(3'b000, 3'b000, 1'b1, 2, 2'b00, 3'b001, 2'd0, 1'b0, 3'b100);
        add(3'b000, 3'b000, 1'b1, 1, 2'b00, 3'b000, 2'd0, 1'b0, 3'b100);
        add(3'b000, 3'b000, 1'b0, 1, 2'b10, 3'b000, 2'd0, 1'b1, 3'b100);
        add(3'b000, 3'b010, 1'b1, 1, 2'b10, 3'b000, 2'd0, 1'b1, 3'b110);
        add(3'b000, 3'b000, 1'b1, 1, 2'b10, 3'b000, 2'd0, 1'b1, 3'b110);
        add(3'b000, 3'b000, 1'b1, 1, 2'b00, 3'b010, 2'd1, 1'b1, 3'b100);
        add(3'b000, 3'b000, 1'b1, 3, 2'b00, 3'b010, 2'd1, 1'b1, 3'b100);
        add(3'b000, 3'b000, 1'b1, 1, 2'b00, 3'b000, 2'd1, 1'b1, 3'b100);
        add(3'b000, 3'b000, 1'b0, 1, 2'b10, 3'b000, 2'd1, 1'b1, 3'b100);
        add(3'b000, 3'b000, 1'b1, 2, 2'b10, 3'b000, 2'd1, 1'b1, 3'b100);
        add(3'b000, 3'b000, 1'b1, 1, 2'b00, 3'b100, 2'd2, 1'b1, 3'b000);
        // idle car, call at its own floor: door opens two edges after press
        add(3'b000, 3'b000, 1'b1, 3, 2'b00, 3'b100, 2'd2, 1'b1, 3'b000);
        add(3'b000, 3'b000, 1'b1, 1, 2'b00, 3'b000, 2'd2, 1'b1, 3'b000);
        add(3'b100, 3'b000, 1'b0, 1, 2'b00, 3'b000, 2'd2, 1'b1, 3'b100);
        add(3'b000, 3'b000, 1'b0, 1, 2'b00, 3'b100, 2'd2, 1'b1, 3'b000);

        cycle();
        cycle();
        check("reset3", snap3(), 32'({2'b00, 3'b001, 2'd0, 1'b1, 3'b000}));
        check("reset8 doors", 32'(if8.doors), 32'h01);
        check("reset8 engine", 32'(if8.engine), 32'h0);
        RST = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            for (int r = 0; r < vecs[k].rep; r++) begin
                if3.interior_panel = vecs[k].ip;
                if3.exterior_panel = vecs[k].ep;
                if3.tick           = vecs[k].tk;
                cycle();
                check($sformatf("vec%0d.%0d", k, r), snap3(),
                      32'({vecs[k].eng, vecs[k].drs, vecs[k].cur, vecs[k].dir, vecs[k].req}));
            end
        end

        // reset while moving down from floor 2 towards a call at floor 0
        if3.interior_panel = 3'b001;
        if3.exterior_panel = 3'b000;
        if3.tick = 1'b0;
        cycle();
        if3.interior_panel = 3'b000;
        if3.tick = 1'b1;
        repeat (9) cycle();
        check("pre-reset moving", snap3(), 32'({2'b11, 3'b000, 2'd1, 1'b0, 3'b001}));
        RST = 1'b0;
        #1;
        check("async reset", snap3(), 32'({2'b00, 3'b001, 2'd0, 1'b1, 3'b000}));
        cycle();
        check("reset held", snap3(), 32'({2'b00, 3'b001, 2'd0, 1'b1, 3'b000}));
        if3.tick = 1'b0;
        RST = 1'b1;

        // 8 floors: park at 4 going up, then calls at 7 and 2
        if8.interior_panel = 8'h10;
        cycle();
        if8.interior_panel = 8'h00;
        check("f8 req4", 32'(if8.requests), 32'h10);
        wait_door8("f8 to4", 17, 3'd4, 8'h10, 1'b1);
        if8.exterior_panel = 8'h84;
        cycle();
        if8.exterior_panel = 8'h00;
        check("f8 req 7+2", 32'(if8.requests), 32'h84);
        wait_door8("f8 to7", 14, 3'd7, 8'h80, 1'b1);
        check("f8 req after 7", 32'(if8.requests), 32'h04);
        wait_door8("f8 to2", 20, 3'd2, 8'h04, 1'b0);
        check("f8 req after 2", 32'(if8.requests), 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
